// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, bus types and control encodings for the register file
package regfile_pkg;
   localparam int RegWidth   = 32;
   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;
   typedef logic [RegWidth-1:0]   RegBus;
   typedef logic [RegNumLog2-1:0] RegAddrBus;
   localparam RegBus     ZeroWord     = '0;
   localparam RegAddrBus NOPRegAddr   = 5'b00000;
   localparam logic      WriteEnable  = 1'b1;
   localparam logic      WriteDisable = 1'b0;
   localparam logic      ReadEnable   = 1'b1;
   localparam logic      ReadDisable  = 1'b0;
   localparam logic      RstEnable    = 1'b0;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: combinational read port with zero/enable gating; REGFILE_WRITE_BYPASS_EN adds same-cycle write forwarding
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W = RegWidth,
   parameter int ADDR_W = RegNumLog2
) (
   input  logic              rst_n_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic [DATA_W-1:0] stored_i,
`ifdef REGFILE_WRITE_BYPASS_EN
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
`endif
   output logic [DATA_W-1:0] rdata_o
);
   logic off;
   assign off = (rst_n_i == RstEnable) || (re_i != ReadEnable) || (raddr_i == ADDR_W'(NOPRegAddr));
   // gated read; a matching in-flight write wins over the array when forwarding is built in
   always_comb begin
      rdata_o = DATA_W'(ZeroWord);
`ifdef REGFILE_WRITE_BYPASS_EN
      if (!off) rdata_o = (we_i == WriteEnable && waddr_i == raddr_i) ? wdata_i : stored_i;
`else
      if (!off) rdata_o = stored_i;
`endif
   end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, one write port, two gated read ports, r0 hardwired to zero; REGFILE_WRITE_BYPASS_EN enables write-to-read forwarding
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W = RegWidth,
   parameter int ADDR_W = RegNumLog2,
   parameter int NREG   = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   // next array contents: one write per cycle, writes to r0 dropped
   always_comb begin
      regs_d = regs_q;
      if (we == WriteEnable && waddr != ADDR_W'(NOPRegAddr)) regs_d[waddr] = wdata;
   end
   // array state; reset clears every entry and blocks writes while held
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end
   regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .rst_n_i  (rst),
      .re_i     (re1),
      .raddr_i  (raddr1),
      .stored_i (regs_q[raddr1]),
`ifdef REGFILE_WRITE_BYPASS_EN
      .we_i     (we),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
`endif
      .rdata_o  (rdata1)
   );
   regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .rst_n_i  (rst),
      .re_i     (re2),
      .raddr_i  (raddr2),
      .stored_i (regs_q[raddr2]),
`ifdef REGFILE_WRITE_BYPASS_EN
      .we_i     (we),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
`endif
      .rdata_o  (rdata2)
   );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile; expectations follow REGFILE_WRITE_BYPASS_EN when defined
module tb_regfile;
   logic        clk = 1'b0;
   logic        rst, we, re1, re2;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata, rdata1, rdata2;
   int vectors = 0;
   int miscompares = 0;

   regfile dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1;
      waddr = a;
      wdata = d;
      edge1();
      we = 1'b0;
   endtask

   initial begin
      rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
      edge1();
      edge1();
      chk("rst_rd1", rdata1, 32'h0);
      chk("rst_rd2", rdata2, 32'h0);
      rst = 1'b1; we = 1'b0;
      #1;
      chk("post_rst_r5", rdata1, 32'h0);
      edge1();
      chk("post_rst_r5_edge", rdata1, 32'h0);

      wr(5'd3, 32'h12345678);
      raddr1 = 5'd3; raddr2 = 5'd3; re1 = 1'b1; re2 = 1'b1;
      #1;
      chk("r3_p1", rdata1, 32'h12345678);
      chk("r3_p2", rdata2, 32'h12345678);

      wr(5'd10, 32'h000000AA);
      wr(5'd11, 32'h000000BB);
      raddr1 = 5'd10; raddr2 = 5'd11;
      #1;
      chk("r10_p1", rdata1, 32'h000000AA);
      chk("r11_p2", rdata2, 32'h000000BB);

      wr(5'd0, 32'hFFFFFFFF);
      raddr1 = 5'd0;
      #1;
      chk("r0_after_wr", rdata1, 32'h0);
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      chk("r0_same_cycle_p1", rdata1, 32'h0);
      chk("r0_same_cycle_p2", rdata2, 32'h0);
      edge1();
      we = 1'b0;
      #1;
      chk("r0_next_cycle", rdata1, 32'h0);

      wr(5'd7, 32'hA5A5A5A5);
      raddr2 = 5'd7; re2 = 1'b0;
      #1;
      chk("r7_re2_off", rdata2, 32'h0);
      re2 = 1'b1;
      #1;
      chk("r7_re2_on", rdata2, 32'hA5A5A5A5);
      raddr1 = 5'd3; re1 = 1'b0;
      #1;
      chk("r3_re1_off", rdata1, 32'h0);
      re1 = 1'b1;

      wr(5'd9, 32'h1);
      we = 1'b1; waddr = 5'd9; wdata = 32'h2;
      raddr1 = 5'd9; re1 = 1'b1; raddr2 = 5'd9; re2 = 1'b0;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      chk("byp_same_cycle", rdata1, 32'h2);
`else
      chk("byp_same_cycle", rdata1, 32'h1);
`endif
      chk("byp_re2_off", rdata2, 32'h0);
      raddr1 = 5'd7;
      #1;
      chk("byp_other_addr", rdata1, 32'hA5A5A5A5);
      raddr1 = 5'd9;
      edge1();
      we = 1'b0;
      #1;
      chk("byp_next_cycle", rdata1, 32'h2);

      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
      re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd31; raddr2 = 5'd17;
      #1;
      chk("fill_r31", rdata1, 32'd31);
      chk("fill_r17", rdata2, 32'd17);
      raddr1 = 5'd1; raddr2 = 5'd16;
      #1;
      chk("fill_r1", rdata1, 32'd1);
      chk("fill_r16", rdata2, 32'd16);

      rst = 1'b0;
      #1;
      chk("async_rst_p1", rdata1, 32'h0);
      chk("async_rst_p2", rdata2, 32'h0);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         chk($sformatf("clr_p1_r%0d", i), rdata1, 32'h0);
         chk($sformatf("clr_p2_r%0d", 31 - i), rdata2, 32'h0);
      end

      edge1();
      wr(5'd4, 32'h0000002C);
      raddr1 = 5'd4;
      #1;
      chk("r4_after_async", rdata1, 32'h0000002C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
